// File: rtl/dr_pkg.sv
// dr_pkg: shared frame constants, sequencer states and the dr select pattern
package dr_pkg;
    localparam int FRAME_LEN = 16;
    localparam int SLOT_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    function automatic logic [1:0] dr_sel(input logic [SLOT_W-1:0] i);
        return {~(i[3] ^ i[0]), ~(i[2] ^ i[1])};
    endfunction
endpackage

// File: rtl/dr_seq_if.sv
// dr_seq_if: valid/ready sample stream feeding the dr sequencer
interface dr_seq_if #(parameter int N = 8);
    logic in_valid;
    logic in_ready;
    logic [N-1:0] in_data;
    modport master(output in_valid, in_data, input in_ready);
    modport slave(input in_valid, in_data, output in_ready);
endinterface

// File: rtl/dr_sel_gen.sv
// dr_sel_gen: slot counter and registered dr select lines, free-running while enabled
module dr_sel_gen import dr_pkg::*; (
    input  logic              clk,
    input  logic              clear,
    input  logic              en,
    output logic [SLOT_W-1:0] i,
    output logic              s0,
    output logic              s1
);
    always_ff @(posedge clk)
        if (clear || !en) begin
            i <= '0;
            {s0, s1} <= 2'b00;
        end else begin
            i <= i + 1'b1;
            {s0, s1} <= dr_sel(i);
        end
endmodule

// File: rtl/dr_seq.sv
// dr_seq: frames a sample stream into 16-slot blocks for dr, then flushes dr's pipeline
module dr_seq import dr_pkg::*; #(
    parameter int N = 8,
    parameter int DR_LAT = 3
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         start,
    dr_seq_if.slave      src,
    output logic [N-1:0] d,
    output logic         s0,
    output logic         s1,
    output logic         busy,
    output logic         frame_done,
    output logic         underrun
);
    localparam int FW = $clog2(DR_LAT + 1);
    localparam logic [FW-1:0] FLAST = FW'(DR_LAT - 1);
    state_t state;
    logic [FW-1:0] f;
    logic [SLOT_W-1:0] i;
    assign src.in_ready = state == RUN;
    assign busy = state != IDLE;
    dr_sel_gen u_sel (.clk(clk), .clear(clear), .en(busy), .i(i), .s0(s0), .s1(s1));
    // frame_done is raised one cycle early so it is high during the last flush cycle
    always_ff @(posedge clk)
        if (clear) begin
            state <= IDLE;
            f <= '0;
            d <= '0;
            frame_done <= 1'b0;
            underrun <= 1'b0;
        end else begin
            d <= '0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    f <= '0;
                    if (start) begin
                        state <= RUN;
                        underrun <= 1'b0;
                    end
                end
                RUN: begin
                    d <= src.in_valid ? src.in_data : '0;
                    if (!src.in_valid) underrun <= 1'b1;
                    if (i == SLOT_W'(FRAME_LEN - 1)) begin
                        state <= FLUSH;
                        f <= '0;
                        frame_done <= FLAST == '0;
                    end
                end
                FLUSH:
                    if (f == FLAST) begin
                        state <= IDLE;
                        f <= '0;
                    end else begin
                        f <= f + 1'b1;
                        frame_done <= f + 1'b1 == FLAST;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_dr_seq.sv
// tb_dr_seq: directed frames; driver queues expected dr samples, monitor checks them
module tb_dr_seq;
    import dr_pkg::*;
    localparam int N = 8;
    localparam int LAT = 3;
    logic clk = 1'b0;
    logic clear, start;
    logic [N-1:0] d;
    logic s0, s1, busy, frame_done, underrun;
    dr_seq_if #(.N(N)) sif ();
    dr_seq #(.N(N), .DR_LAT(LAT)) dut (
        .clk(clk), .clear(clear), .start(start), .src(sif.slave),
        .d(d), .s0(s0), .s1(s1), .busy(busy), .frame_done(frame_done), .underrun(underrun)
    );
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    logic [N+1:0] sb[$];
    logic [1:0] pat[16] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd2, 2'd0, 2'd3, 2'd1,
                            2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd2, 2'd1, 2'd3};
    logic [N-1:0] va[16] = '{8'd1, 8'd2, 8'd5, 8'd6, 8'd8, 8'd10, 8'd12, 8'd13,
                             8'd12, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd6, 8'd9};
    logic [N-1:0] vb[16] = '{8'h20, 8'h31, 8'h42, 8'h53, 8'h64, 8'h75, 8'h86, 8'h97,
                             8'ha8, 8'hb9, 8'hca, 8'hdb, 8'hec, 8'hfd, 8'h0e, 8'h1f};
    logic [N-1:0] v[16];
    logic bq = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) bq <= busy && !clear;
    always @(negedge clk)
        if (bq) begin
            if (sb.size() == 0) chk("sb_empty", sb.size(), 1);
            else chk("dout", {d, s0, s1}, sb.pop_front());
        end

    task automatic idle_zero(input string nm, input logic exp_ur);
        chk({nm, "_d"}, d, 0);
        chk({nm, "_sel"}, {s0, s1}, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_ready"}, sif.in_ready, 0);
        chk({nm, "_done"}, frame_done, 0);
        chk({nm, "_underrun"}, underrun, exp_ur);
    endtask

    task automatic frame(input int starve, input int abort, input bit hold, input bit spulse);
        start = 1'b1;
        for (int k = 0; k < 16 + LAT; k++) begin
            @(negedge clk);
            start = hold || (spulse && (k == 8 || k == 17));
            chk("in_ready", sif.in_ready, k < 16);
            chk("busy", busy, 1);
            chk("frame_done", frame_done, k == 15 + LAT);
            chk("underrun", underrun, starve >= 0 && k > starve);
            if (k == abort) begin
                clear = 1'b1;
                sif.in_valid = 1'b1;
                sif.in_data = v[k];
                @(negedge clk);
                clear = 1'b0;
                start = 1'b0;
                sif.in_valid = 1'b0;
                idle_zero("abort", 1'b0);
                chk("abort_slot", dut.u_sel.i, 0);
                return;
            end
            sif.in_valid = (k < 16) ? (k != starve) : 1'($urandom);
            sif.in_data = (k < 16) ? v[k] : N'($urandom);
            sb.push_back({(k < 16 && k != starve) ? v[k] : {N{1'b0}}, pat[k % 16]});
        end
        @(negedge clk);
        sif.in_valid = 1'b0;
        chk("end_busy", busy, 0);
        chk("end_ready", sif.in_ready, 0);
        chk("end_done", frame_done, 0);
        chk("end_underrun", underrun, starve >= 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b1;
        repeat (2) begin
            start = 1'($urandom);
            sif.in_valid = 1'($urandom);
            sif.in_data = N'($urandom);
            @(negedge clk);
        end
        idle_zero("reset", 1'b0);
        chk("reset_slot", dut.u_sel.i, 0);
        clear = 1'b0;
        start = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_data = '0;
        v = va;
        frame(-1, -1, 1'b0, 1'b0);
        v = vb;
        frame(5, -1, 1'b0, 1'b0);
        v = va;
        frame(-1, -1, 1'b0, 1'b1);
        v = vb;
        frame(-1, 10, 1'b0, 1'b0);
        frame(-1, -1, 1'b0, 1'b0);
        v = va;
        frame(-1, -1, 1'b1, 1'b0);
        v = vb;
        frame(-1, -1, 1'b0, 1'b0);
        @(negedge clk);
        idle_zero("final", 1'b0);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
